// File: rtl/da_pkg.sv
// Shared definitions for the DA FIR sequencer: state encoding, SRAM strobe levels, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package da_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLANE,
    S_DRAIN,
    S_OUT
  } state_e;

  // The LUT SRAM strobes are active-low.
  localparam logic ON  = 1'b0;
  localparam logic OFF = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/da_delay_line.sv
// WIDTH x DEPTH shift register that aligns control bits with a downstream pipeline.
// Latency: exactly DEPTH cycles from din to dout.
// Backpressure: none; advances every cycle, cleared to zero by reset.
module da_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;
  logic [DEPTH-1:0][WIDTH-1:0] sr_d;

  // Next shift state: new word enters stage 0, everything else moves one stage on.
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Stage registers; reset flushes any in-flight controls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/da_seq_ctrl.sv
// Sequencer for the bit-serial DA FIR: LUT load, DATA_W bit-planes per sample, aligned accumulator controls.
// Latency: sample handshake to out_valid is DATA_W+PIPE+1 cycles; one LUT word per cycle during load.
// Backpressure: out_valid holds until out_ready; in_ready stays low until the result is taken.
module da_seq_ctrl
  import da_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 4,
  parameter int N_PART = 2,
  parameter int PIPE   = 2
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                cload,
  input  logic                                coef_valid,
  output logic                                coef_ready,
  output logic [K+clog2_min1(N_PART)-1:0]     rom_waddr,
  output logic                                rom_cen,
  output logic                                rom_wen,
  output logic                                load_done,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                load_zreg,
  output logic                                shift_en,
  output logic [clog2_min1(DATA_W)-1:0]       bit_idx,
  output logic                                acc_clr,
  output logic                                acc_en,
  output logic                                acc_sub,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int PW    = clog2_min1(N_PART);
  localparam int BW    = clog2_min1(DATA_W);
  localparam int AW    = K + PW;
  localparam int DW    = clog2_min1(PIPE);
  localparam int TOTAL = N_PART << K;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            load_done_q, load_done_d;

  // Undelayed accumulator controls, valid in the plane cycle that reads the ROM.
  logic            en_raw, clr_raw, sub_raw;
  logic [2:0]      acc_ctl;

  // State and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      bit_q       <= '0;
      dcnt_q      <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bit_q       <= bit_d;
      dcnt_q      <= dcnt_d;
      load_done_q <= load_done_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    bit_d       = bit_q;
    dcnt_d      = dcnt_q;
    load_done_d = load_done_q;
    coef_ready  = 1'b0;
    rom_cen     = OFF;
    rom_wen     = OFF;
    in_ready    = 1'b0;
    load_zreg   = 1'b0;
    shift_en    = 1'b0;
    out_valid   = 1'b0;
    en_raw      = 1'b0;
    clr_raw     = 1'b0;
    sub_raw     = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_d   = '0;
        in_ready = load_done_q & ~cload;
        if (cload) begin
          // A new load overwrites the LUT, so the old contents are no longer trusted.
          state_d     = S_LOAD;
          load_done_d = 1'b0;
        end else if (in_valid && load_done_q) begin
          load_zreg = 1'b1;
          bit_d     = '0;
          state_d   = S_PLANE;
        end
      end

      S_LOAD: begin
        coef_ready = 1'b1;
        if (coef_valid) begin
          rom_cen = ON;
          rom_wen = ON;
          addr_d  = addr_q + AW'(1);
          if (addr_q == AW'(TOTAL - 1)) begin
            load_done_d = 1'b1;
            addr_d      = '0;
            state_d     = S_IDLE;
          end
        end
        // Dropping cload abandons the partial load; the LUT must be rewritten from 0.
        if (!cload) begin
          load_done_d = 1'b0;
          addr_d      = '0;
          state_d     = S_IDLE;
        end
      end

      S_PLANE: begin
        rom_cen  = ON;
        shift_en = 1'b1;
        en_raw   = 1'b1;
        clr_raw  = (bit_q == '0);
        // MSB plane carries negative weight in two's complement.
        sub_raw  = (bit_q == BW'(DATA_W - 1));
        if (bit_q == BW'(DATA_W - 1)) begin
          bit_d   = '0;
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end

      S_DRAIN: begin
        // Wait for the last plane's partial sum to clear the accumulator pipeline.
        if (dcnt_q == DW'(PIPE - 1)) begin
          dcnt_d  = '0;
          state_d = S_OUT;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rom_waddr = addr_q;
  assign bit_idx   = bit_q;
  assign load_done = load_done_q;

  da_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE)
  ) u_acc_dly (
    .clk    (clk),
    .resetn (resetn),
    .din    ({en_raw, clr_raw, sub_raw}),
    .dout   (acc_ctl)
  );

  assign acc_en  = acc_ctl[2];
  assign acc_clr = acc_ctl[1];
  assign acc_sub = acc_ctl[0];

endmodule

// File: tb/tb_da_seq_ctrl.sv
// Directed bench for da_seq_ctrl with DATA_W=8, K=4, N_PART=2, PIPE=2.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_da_seq_ctrl;

  localparam int TOTAL = 32;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cload, coef_valid, coef_ready;
  logic [4:0] rom_waddr;
  logic       rom_cen, rom_wen, load_done;
  logic       in_valid, in_ready, load_zreg, shift_en;
  logic [2:0] bit_idx;
  logic       acc_clr, acc_en, acc_sub;
  logic       out_valid, out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  da_seq_ctrl #(
    .DATA_W (8),
    .K      (4),
    .N_PART (2),
    .PIPE   (2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cload      (cload),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .rom_waddr  (rom_waddr),
    .rom_cen    (rom_cen),
    .rom_wen    (rom_wen),
    .load_done  (load_done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .load_zreg  (load_zreg),
    .shift_en   (shift_en),
    .bit_idx    (bit_idx),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .acc_sub    (acc_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  typedef struct packed {
    logic       in_ready;
    logic       load_zreg;
    logic       shift_en;
    logic [2:0] bit_idx;
    logic       rom_cen;
    logic       rom_wen;
    logic       acc_en;
    logic       acc_clr;
    logic       acc_sub;
    logic       out_valid;
    logic       coef_ready;
  } obs_t;

  typedef struct packed {
    logic in_valid;
    logic out_ready;
    obs_t exp;
  } vec_t;

  vec_t tbl[16];
  int   n_rows = 0;

  function automatic obs_t mk(input logic ir, input logic zr, input logic se, input logic [2:0] bi,
                              input logic cen, input logic wen, input logic en, input logic clr,
                              input logic sub, input logic ov);
    obs_t o;
    o.in_ready   = ir;
    o.load_zreg  = zr;
    o.shift_en   = se;
    o.bit_idx    = bi;
    o.rom_cen    = cen;
    o.rom_wen    = wen;
    o.acc_en     = en;
    o.acc_clr    = clr;
    o.acc_sub    = sub;
    o.out_valid  = ov;
    o.coef_ready = 1'b0;
    return o;
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o.in_ready   = in_ready;
    o.load_zreg  = load_zreg;
    o.shift_en   = shift_en;
    o.bit_idx    = bit_idx;
    o.rom_cen    = rom_cen;
    o.rom_wen    = rom_wen;
    o.acc_en     = acc_en;
    o.acc_clr    = acc_clr;
    o.acc_sub    = acc_sub;
    o.out_valid  = out_valid;
    o.coef_ready = coef_ready;
    return o;
  endfunction

  task automatic add_row(input logic iv, input logic ordy, input obs_t e);
    tbl[n_rows].in_valid  = iv;
    tbl[n_rows].out_ready = ordy;
    tbl[n_rows].exp       = e;
    n_rows++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle boundary: inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full LUT load from IDLE, with one idle beat in the middle; leaves the block in IDLE.
  task automatic full_load();
    cload      = 1'b1;
    coef_valid = 1'b1;
    in_valid   = 1'b0;
    #2 chk("load_idle_cycle", 32'({coef_ready, rom_cen, rom_wen}), 32'(3'b011));
    next_cycle();
    for (int i = 0; i < TOTAL; i++) begin
      if (i == 16) begin
        coef_valid = 1'b0;
        #2 chk("load_gap", 32'({coef_ready, rom_cen, rom_wen, rom_waddr}), 32'({3'b111, 5'd16}));
        next_cycle();
        coef_valid = 1'b1;
      end
      #2 chk($sformatf("load_beat_%0d", i), 32'({coef_ready, rom_cen, rom_wen, rom_waddr}),
             32'({3'b100, 5'(i)}));
      if (i == TOTAL - 1) begin
        chk("load_done_before_end", 32'(load_done), 32'(0));
      end
      next_cycle();
    end
    cload      = 1'b0;
    coef_valid = 1'b0;
    #2 chk("load_done_after", 32'({load_done, in_ready, coef_ready, rom_cen}), 32'(4'b1101));
    next_cycle();
  endtask

  initial begin
    logic bad;
    obs_t rst_obs;
    rst_obs = mk(0, 0, 0, 3'd0, 1, 1, 0, 0, 0, 0);

    // Single-sample schedule: handshake at row 0, a second back-to-back handshake at row 12.
    add_row(1, 0, mk(1, 1, 0, 3'd0, 1, 1, 0, 0, 0, 0));
    for (int c = 1; c <= 8; c++) begin
      add_row(1, 0, mk(0, 0, 1, 3'(c - 1), 0, 1, logic'(c >= 3), logic'(c == 3), 0, 0));
    end
    add_row(1, 0, mk(0, 0, 0, 3'd0, 1, 1, 1, 0, 0, 0));
    add_row(1, 0, mk(0, 0, 0, 3'd0, 1, 1, 1, 0, 1, 0));
    add_row(1, 1, mk(0, 0, 0, 3'd0, 1, 1, 0, 0, 0, 1));
    add_row(1, 0, mk(1, 1, 0, 3'd0, 1, 1, 0, 0, 0, 0));

    resetn     = 1'b0;
    cload      = 1'b0;
    coef_valid = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    #2 chk("reset_obs", 32'(get_obs()), 32'(rst_obs));
    chk("reset_load", 32'({load_done, rom_waddr}), 32'(0));
    next_cycle();
    next_cycle();
    resetn = 1'b1;

    // Aborted load: 10 beats then cload drops.
    cload      = 1'b1;
    coef_valid = 1'b1;
    #2 next_cycle();
    for (int i = 0; i < 10; i++) begin
      #2 chk($sformatf("abort_beat_%0d", i), 32'({coef_ready, rom_cen, rom_wen, rom_waddr}),
             32'({3'b100, 5'(i)}));
      next_cycle();
    end
    cload      = 1'b0;
    coef_valid = 1'b0;
    #2 next_cycle();
    for (int i = 0; i < 3; i++) begin
      #2 chk("abort_no_sample", 32'({load_done, in_ready, load_zreg, coef_ready}), 32'(0));
      next_cycle();
    end

    full_load();

    // Table-driven single sample followed by an immediate second handshake.
    for (int r = 0; r < n_rows; r++) begin
      in_valid  = tbl[r].in_valid;
      out_ready = tbl[r].out_ready;
      #2 chk($sformatf("sample_row_%0d", r), 32'(get_obs()), 32'(tbl[r].exp));
      next_cycle();
    end

    // Backpressure on the second sample: result held for 5 cycles.
    repeat (10) next_cycle();
    for (int k = 0; k < 5; k++) begin
      #2 chk($sformatf("bp_hold_%0d", k), 32'({out_valid, in_ready, load_zreg}), 32'(3'b100));
      next_cycle();
    end
    out_ready = 1'b1;
    #2 chk("bp_release", 32'({out_valid, in_ready}), 32'(2'b10));
    next_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 chk("bp_in_ready_back", 32'({out_valid, in_ready}), 32'(2'b01));

    // cload raised during the planes is ignored until the sample finishes.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #2 next_cycle();
    in_valid = 1'b0;
    cload    = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      #2 chk($sformatf("cload_plane_%0d", c), 32'({shift_en, bit_idx, coef_ready, in_ready}),
             32'({1'b1, 3'(c - 1), 2'b00}));
      next_cycle();
    end
    repeat (2) next_cycle();
    #2 chk("cload_out", 32'({out_valid, coef_ready}), 32'(2'b10));
    next_cycle();
    #2 chk("cload_idle", 32'({coef_ready, in_ready, out_valid}), 32'(0));
    next_cycle();
    #2 chk("cload_enters_load", 32'(coef_ready), 32'(1));
    cload = 1'b0;
    next_cycle();

    full_load();

    // Asynchronous reset in the middle of plane 4.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #2 next_cycle();
    in_valid = 1'b0;
    repeat (4) next_cycle();
    #2 chk("pre_reset_plane4", 32'({shift_en, bit_idx, acc_en}), 32'({1'b1, 3'd4, 1'b1}));
    resetn = 1'b0;
    #1 chk("async_reset_obs", 32'(get_obs()), 32'(rst_obs));
    chk("async_reset_load_done", 32'(load_done), 32'(0));
    next_cycle();
    next_cycle();
    resetn   = 1'b1;
    in_valid = 1'b1;
    bad      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2 if (acc_en || out_valid || shift_en || in_ready) bad = 1'b1;
      next_cycle();
    end
    chk("no_activity_after_reset", 32'(bad), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
